// File: rtl/multi_port_toggle_memory.sv
// multi_port_toggle_memory: 1-bit entries spread over one bank per toggle port, value = XOR of banks.
// Define MULTI_PORT_TOGGLE_MEMORY_FORWARD_EN to forward same-cycle accepted toggles onto read_data.
module multi_port_toggle_memory #(
    parameter int DEPTH = 8,
    parameter int NUM_TOGGLE_PORTS = 2,
    parameter int NUM_READ_PORTS = 2
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             clear,
    output logic                                             ready,
    input  logic [NUM_TOGGLE_PORTS-1:0]                      toggle,
    input  logic [NUM_TOGGLE_PORTS-1:0][$clog2(DEPTH)-1:0]   toggle_id,
    input  logic [NUM_READ_PORTS-1:0][$clog2(DEPTH)-1:0]     read_id,
    output logic [NUM_READ_PORTS-1:0]                        read_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] CLEARING = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0] state;
    logic [AW-1:0] cnt;
    logic [NUM_TOGGLE_PORTS-1:0] accept;
    logic [DEPTH-1:0] bank [NUM_TOGGLE_PORTS];

    assign ready = state == READY;
    assign accept = toggle & {NUM_TOGGLE_PORTS{ready & ~clear}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEARING;
            cnt <= '0;
        end else if (clear) begin
            state <= CLEARING;
            cnt <= '0;
        end else if (state == CLEARING) begin
            cnt <= cnt + AW'(1);
            if (cnt == AW'(DEPTH - 1)) state <= READY;
        end
    end

    // Each port flips only its own bank, so k same-entry toggles give k net inversions.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_TOGGLE_PORTS; p++) begin
            if (!ready) bank[p][cnt] <= 1'b0;
            else if (accept[p]) bank[p][toggle_id[p]] <= ~bank[p][toggle_id[p]];
        end
    end

    always_comb begin
        read_data = '0;
        for (int r = 0; r < NUM_READ_PORTS; r++) begin
            for (int p = 0; p < NUM_TOGGLE_PORTS; p++) begin
                read_data[r] = read_data[r] ^ bank[p][read_id[r]];
`ifdef MULTI_PORT_TOGGLE_MEMORY_FORWARD_EN
                read_data[r] = read_data[r] ^ (accept[p] & (toggle_id[p] == read_id[r]));
`else
`endif
            end
        end
        read_data = read_data & {NUM_READ_PORTS{ready}};
    end
endmodule

// File: tb/tb_multi_port_toggle_memory.sv
// tb_multi_port_toggle_memory: directed checks of sweep, toggles, clear and reset for DEPTH=8, 2x2 ports.
module tb_multi_port_toggle_memory;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;
    logic ready;
    logic [1:0] toggle = '0;
    logic [1:0][2:0] toggle_id = '0;
    logic [1:0][2:0] read_id = '0;
    logic [1:0] read_data;
    int checks = 0;
    int failures = 0;

    multi_port_toggle_memory #(.DEPTH(8), .NUM_TOGGLE_PORTS(2), .NUM_READ_PORTS(2)) dut (
        .clk(clk), .rst(rst), .clear(clear), .ready(ready), .toggle(toggle),
        .toggle_id(toggle_id), .read_id(read_id), .read_data(read_data)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || read_data !== 2'b00) begin
            failures++;
            $display("FAIL reset_hold ready=%b read_data=%b expected ready=0 read_data=00", ready, read_data);
        end
        step();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_sweep_cycle%0d ready=%b expected 0", i, ready);
            end
            step();
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready ready=%b expected 1", ready);
        end
        for (int i = 0; i < 8; i++) begin
            read_id[0] = 3'(i);
            read_id[1] = 3'(7 - i);
            #1;
            checks++;
            if (read_data !== 2'b00) begin
                failures++;
                $display("FAIL reset_entry%0d read_data=%b expected 00", i, read_data);
            end
        end
    endtask

    task automatic test_single_toggle;
        read_id[0] = 3'd3;
        toggle = 2'b01;
        toggle_id[0] = 3'd3;
        #1;
        checks++;
`ifdef MULTI_PORT_TOGGLE_MEMORY_FORWARD_EN
        if (read_data[0] !== 1'b1) begin
            failures++;
            $display("FAIL fwd_same_cycle id3 read=%b expected 1", read_data[0]);
        end
`else
        if (read_data[0] !== 1'b0) begin
            failures++;
            $display("FAIL no_fwd_same_cycle id3 read=%b expected 0", read_data[0]);
        end
`endif
        step();
        toggle = 2'b00;
        #1;
        checks++;
        if (read_data[0] !== 1'b1) begin
            failures++;
            $display("FAIL toggle_set id3 read=%b expected 1", read_data[0]);
        end
        toggle = 2'b01;
        step();
        toggle = 2'b00;
        #1;
        checks++;
        if (read_data[0] !== 1'b0) begin
            failures++;
            $display("FAIL toggle_back id3 read=%b expected 0", read_data[0]);
        end
    endtask

    task automatic test_dual_toggle;
        toggle = 2'b11;
        toggle_id[0] = 3'd5;
        toggle_id[1] = 3'd5;
        step();
        toggle = 2'b00;
        read_id[0] = 3'd5;
        #1;
        checks++;
        if (read_data[0] !== 1'b0) begin
            failures++;
            $display("FAIL same_entry_cancel id5 read=%b expected 0", read_data[0]);
        end
        toggle = 2'b11;
        toggle_id[0] = 3'd2;
        toggle_id[1] = 3'd6;
        step();
        toggle = 2'b00;
        read_id[0] = 3'd2;
        read_id[1] = 3'd6;
        #1;
        checks++;
        if (read_data !== 2'b11) begin
            failures++;
            $display("FAIL dual_distinct id2/id6 read=%b expected 11", read_data);
        end
        read_id[0] = 3'd3;
        read_id[1] = 3'd5;
        #1;
        checks++;
        if (read_data !== 2'b00) begin
            failures++;
            $display("FAIL dual_others id3/id5 read=%b expected 00", read_data);
        end
    endtask

    task automatic test_clear;
        toggle = 2'b11;
        toggle_id[0] = 3'd1;
        toggle_id[1] = 3'd4;
        step();
        toggle = 2'b00;
        read_id[0] = 3'd1;
        read_id[1] = 3'd4;
        #1;
        checks++;
        if (read_data !== 2'b11) begin
            failures++;
            $display("FAIL clear_setup id1/id4 read=%b expected 11", read_data);
        end
        clear = 1'b1;
        toggle = 2'b01;
        toggle_id[0] = 3'd7;
        step();
        clear = 1'b0;
        toggle = 2'b00;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ready !== 1'b0 || read_data !== 2'b00) begin
                failures++;
                $display("FAIL clear_sweep_cycle%0d ready=%b read_data=%b expected 0/00", i, ready, read_data);
            end
            step();
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL clear_ready ready=%b expected 1", ready);
        end
        for (int i = 0; i < 8; i++) begin
            read_id[0] = 3'(i);
            #1;
            checks++;
            if (read_data[0] !== 1'b0) begin
                failures++;
                $display("FAIL clear_entry%0d read=%b expected 0", i, read_data[0]);
            end
        end
    endtask

    task automatic test_clear_restart;
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        step();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ready !== 1'b0) begin
                failures++;
                $display("FAIL restart_sweep_cycle%0d ready=%b expected 0", i, ready);
            end
            step();
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL restart_ready ready=%b expected 1", ready);
        end
    endtask

    task automatic test_reset_mid_sweep;
        toggle = 2'b01;
        toggle_id[0] = 3'd6;
        step();
        toggle = 2'b00;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || read_data !== 2'b00) begin
            failures++;
            $display("FAIL midsweep_rst ready=%b read_data=%b expected 0/00", ready, read_data);
        end
        step();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            toggle = 2'b01;
            toggle_id[0] = 3'(i);
            #1;
            checks++;
            if (ready !== 1'b0) begin
                failures++;
                $display("FAIL midsweep_cycle%0d ready=%b expected 0", i, ready);
            end
            step();
        end
        toggle = 2'b00;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL midsweep_ready ready=%b expected 1", ready);
        end
        for (int i = 0; i < 8; i++) begin
            read_id[1] = 3'(i);
            #1;
            checks++;
            if (read_data[1] !== 1'b0) begin
                failures++;
                $display("FAIL midsweep_entry%0d read=%b expected 0", i, read_data[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_toggle();
        test_dual_toggle();
        test_clear();
        test_clear_restart();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
